seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one 7-segment bus among NUM_DIGITS common-cathode digits. It sits between the counter/datapath logic and the display pins.
- Double-buffers a packed hex value and sequences the digit enables one at a time.
- Inserts a blanking gap before each digit to prevent ghosting.
- Swaps in new display data only at frame boundaries, so a digit never tears mid-frame.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8
SCAN_DIV, 10000, clock cycles per digit slot; must be greater than BLANK_CYCLES
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off; legal range 1..SCAN_DIV-1
CNT_W, 16, width of the slot counter; must satisfy 2^CNT_W >= SCAN_DIV

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
ena  in  1  scan enable; 0 holds all scan state and forces display outputs to 0
load  in  1  single-cycle strobe that captures value_in and dp_in
value_in  in  4*NUM_DIGITS  packed hex nibbles; nibble 0 (bits 3:0) is the rightmost digit
dp_in  in  NUM_DIGITS  decimal-point request, one bit per digit
segments  out  7  active-high segments, bit0=a .. bit6=g
dp  out  1  decimal point for the currently enabled digit
digit_en  out  NUM_DIGITS  one-hot active-high digit select; all-zero while blanking
frame_tick  out  1  one-cycle pulse at each frame wrap
update_pending  out  1  high while a captured load waits for the next frame

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0; the active buffer, pending buffer and pending flag clear; the digit index is 0; the slot counter is 0; the state is BLANK.
- All outputs are registered.
- Per-slot FSM, two states:
  - BLANK: lasts BLANK_CYCLES cycles; digit_en=0, segments=0, dp=0.
  - SHOW: lasts SCAN_DIV-BLANK_CYCLES cycles; digit_en = one-hot(idx); segments = decode(active nibble idx); dp = active dp bit idx.
  - SHOW -> BLANK at slot end; idx increments and wraps from NUM_DIGITS-1 to 0.
- After reset release with ena=1:
  - the first BLANK_CYCLES cycles are blank;
  - digit 0 is then shown for SCAN_DIV-BLANK_CYCLES cycles;
  - a full frame lasts NUM_DIGITS*SCAN_DIV cycles.
- Frame wrap (transition into the digit-0 BLANK slot):
  - frame_tick=1 for exactly that one cycle;
  - if update_pending, the pending buffer is copied to the active buffer and update_pending clears.
  - frame_tick does not fire when leaving reset.
- Load handling:
  - load=1 writes value_in/dp_in into the pending buffer and sets update_pending the next cycle.
  - A later load before the wrap overwrites the pending buffer; the latest value wins.
  - A load in the same cycle as a wrap bypasses the pending buffer: it goes straight to active and update_pending stays 0.
  - load is honoured even when ena=0.
- ena=0:
  - segments, dp, digit_en and frame_tick are 0 from the next cycle;
  - the slot counter, idx and FSM freeze;
  - scanning resumes from the frozen point when ena returns to 1.
- Decode (hex to segments, 0..F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

Optional Feature:
LZ_BLANK_EN
- Defined: leading-zero suppression. Every digit above the most significant nonzero nibble of the active buffer has digit_en=0, segments=0 and dp=0 during its SHOW slot; slot timing is unchanged. Digit 0 is always shown, so value 0 displays a single "0".
- Undefined: all digits are always shown, including leading zeros.

Test Plan:
Use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 for all scenarios.
1. Release reset with ena=1 -> 2 cycles with digit_en=0000, then 6 cycles with digit_en=0001 and segments=0x3F. The sequence continues 0010, 0100, 1000 with the same 2/6 split. frame_tick pulses at cycle 32, and not at cycle 0.
2. Load 0x1234 with dp_in=0100 at cycle 10 -> update_pending=1 from cycle 11 and the display is unchanged until the wrap at cycle 32. In the next frame: digit0=0x66, digit1=0x4F, digit2=0x5B with dp=1, digit3=0x06. update_pending=0 after the wrap.
3. Load 0x00AB then 0xCDEF within one frame -> the next frame shows 0x71, 0x79, 0x5E, 0x39 (digit0..3); 0xAB is never displayed.
4. Load coincident with the frame_tick cycle -> the value is displayed in that same frame's digit-0 SHOW slot and update_pending never rises.
5. Drop rst_n during digit 2 SHOW -> all outputs are 0 in the same cycle without a clock edge. After release, the bench sees the digit-0 blank slot and active value 0.
6. With LZ_BLANK_EN: value 0x0050 -> digits 3 and 2 keep digit_en=0 during their slots; digit1=0x6D and digit0=0x3F. With value 0x0000 only digit0 lights (0x3F). Without the macro, all four digits light with 0x3F.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Define LZ_BLANK_EN to suppress leading-zero digits.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick,
  output logic                    update_pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  slot_end;
  logic                  wrap_nx;
  logic                  show_nx;
  logic [3:0]            nib_nx;
  logic                  dp_nx;
  logic [6:0]            seg_nx;
  logic [VAL_W-1:0]      active_val, pend_val;
  logic [NUM_DIGITS-1:0] active_dp, pend_dp;
  logic [NUM_DIGITS-1:0] lit;

  // The registers hold the current scan position; outputs are registered from
  // the position being entered so they line up with state in the same cycle.
  always_comb begin
    slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    wrap_nx  = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    state_nx = state;
    if (slot_end) begin
      cnt_nx   = '0;
      state_nx = BLANK;
      idx_nx   = wrap_nx ? '0 : idx + 1'b1;
    end else if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
      state_nx = SHOW;
    end
  end

`ifdef LZ_BLANK_EN
  logic lz_seen;
  always_comb begin
    lz_seen = 1'b0;
    lit     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lz_seen = lz_seen | (|active_val[4*(NUM_DIGITS-1-i) +: 4]);
      lit[NUM_DIGITS-1-i] = lz_seen;
    end
    lit[0] = 1'b1;
  end
`else
  always_comb lit = '1;
`endif

  always_comb begin
    nib_nx  = active_val[{idx_nx, 2'b00} +: 4];
    dp_nx   = active_dp[idx_nx];
    show_nx = (state_nx == SHOW) && lit[idx_nx];
    unique case (nib_nx)
      4'h0: seg_nx = 7'h3F;
      4'h1: seg_nx = 7'h06;
      4'h2: seg_nx = 7'h5B;
      4'h3: seg_nx = 7'h4F;
      4'h4: seg_nx = 7'h66;
      4'h5: seg_nx = 7'h6D;
      4'h6: seg_nx = 7'h7D;
      4'h7: seg_nx = 7'h07;
      4'h8: seg_nx = 7'h7F;
      4'h9: seg_nx = 7'h6F;
      4'hA: seg_nx = 7'h77;
      4'hB: seg_nx = 7'h7C;
      4'hC: seg_nx = 7'h39;
      4'hD: seg_nx = 7'h5E;
      4'hE: seg_nx = 7'h79;
      default: seg_nx = 7'h71;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BLANK;
      cnt            <= '0;
      idx            <= '0;
      segments       <= '0;
      dp             <= 1'b0;
      digit_en       <= '0;
      frame_tick     <= 1'b0;
      update_pending <= 1'b0;
      active_val     <= '0;
      active_dp      <= '0;
      pend_val       <= '0;
      pend_dp        <= '0;
    end else begin
      if (ena) begin
        state      <= state_nx;
        cnt        <= cnt_nx;
        idx        <= idx_nx;
        frame_tick <= wrap_nx;
        digit_en   <= show_nx ? (NUM_DIGITS'(1) << idx_nx) : '0;
        segments   <= show_nx ? seg_nx : '0;
        dp         <= show_nx && dp_nx;
      end else begin
        frame_tick <= 1'b0;
        digit_en   <= '0;
        segments   <= '0;
        dp         <= 1'b0;
      end

      // The swap happens while frame_tick is high: digit 0 is still blanking,
      // so a load in that same cycle can go straight to the active buffer.
      if (load && frame_tick) begin
        active_val     <= value_in;
        active_dp      <= dp_in;
        update_pending <= 1'b0;
      end else begin
        if (frame_tick && update_pending) begin
          active_val     <= pend_val;
          active_dp      <= pend_dp;
          update_pending <= 1'b0;
        end
        if (load) begin
          pend_val       <= value_in;
          pend_dp        <= dp_in;
          update_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_tick;
  logic        update_pending;

  int compared = 0;
  int mismatched = 0;
  int pos = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .load          (load),
    .value_in      (value_in),
    .dp_in         (dp_in),
    .segments      (segments),
    .dp            (dp),
    .digit_en      (digit_en),
    .frame_tick    (frame_tick),
    .update_pending(update_pending)
  );

  // pos counts enabled clock edges since reset release, i.e. the scan position.
  task automatic tick();
    logic e;
    e = ena;
    @(posedge clk);
    #1;
    if (e) pos++;
  endtask

  task automatic do_reset();
    ena   = 1'b1;
    load  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
  endtask

  // Expected {dp, digit_en, segments} at a scan position for a given active value.
  function automatic logic [11:0] expect_out(int p, logic [15:0] v, logic [3:0] d);
    int   slot;
    int   w;
    logic show;
    slot = (p / SD) % ND;
    w    = p % SD;
    show = (w >= BC);
`ifdef LZ_BLANK_EN
    if (slot != 0 && (v >> (4 * slot)) == 16'h0) show = 1'b0;
`endif
    if (!show) return '0;
    return {d[slot], 4'(1 << slot), SEG_TAB[v[4*slot +: 4]]};
  endfunction

  task automatic test_reset();
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({segments, dp, digit_en, frame_tick, update_pending} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_hold got=%h want=0", {segments, dp, digit_en, frame_tick, update_pending});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    compared++;
    if ({segments, dp, digit_en, frame_tick, update_pending} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_release got=%h want=0", {segments, dp, digit_en, frame_tick, update_pending});
    end
  endtask

  task automatic test_scan();
    logic [11:0] want;
    do_reset();
    repeat (41) begin
      want = expect_out(pos, 16'h0, 4'h0);
      compared++;
      if ({dp, digit_en, segments} !== want) begin
        mismatched++;
        $display("FAIL scan pos=%0d got=%h want=%h", pos, {dp, digit_en, segments}, want);
      end
      compared++;
      if (frame_tick !== (pos == 32)) begin
        mismatched++;
        $display("FAIL scan_tick pos=%0d got=%b want=%b", pos, frame_tick, pos == 32);
      end
      tick();
    end
  endtask

  task automatic test_load();
    logic [6:0] tab [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
    logic [3:0] dtab = 4'b0100;
    logic [11:0] want;
    int s;
    do_reset();
    while (pos < 10) tick();
    value_in = 16'h1234;
    dp_in    = 4'b0100;
    load     = 1'b1;
    tick();
    load = 1'b0;
    while (pos < 32) begin
      want = expect_out(pos, 16'h0, 4'h0);
      compared++;
      if ({update_pending, dp, digit_en, segments} !== {1'b1, want}) begin
        mismatched++;
        $display("FAIL load_wait pos=%0d got=%h want=%h", pos, {update_pending, dp, digit_en, segments}, {1'b1, want});
      end
      tick();
    end
    compared++;
    if (frame_tick !== 1'b1) begin
      mismatched++;
      $display("FAIL load_tick got=%b want=1", frame_tick);
    end
    tick();
    while (pos < 64) begin
      s = (pos / SD) % ND;
      want = (pos % SD < BC) ? 12'h0 : {dtab[s], 4'(1 << s), tab[s]};
      compared++;
      if ({update_pending, dp, digit_en, segments} !== {1'b0, want}) begin
        mismatched++;
        $display("FAIL load_show pos=%0d got=%h want=%h", pos, {update_pending, dp, digit_en, segments}, {1'b0, want});
      end
      tick();
    end
  endtask

  task automatic test_overwrite();
    logic [6:0] tab [4] = '{7'h71, 7'h79, 7'h5E, 7'h39};
    logic [11:0] want;
    int s;
    do_reset();
    dp_in = 4'b0000;
    while (pos < 64) begin
      if (segments === 7'h77 || segments === 7'h7C) begin
        mismatched++;
        $display("FAIL overwrite_stale pos=%0d got=%h want=not 77/7C", pos, segments);
      end
      if (pos >= 33) begin
        s = (pos / SD) % ND;
        want = (pos % SD < BC) ? 12'h0 : {1'b0, 4'(1 << s), tab[s]};
        compared++;
        if ({dp, digit_en, segments} !== want) begin
          mismatched++;
          $display("FAIL overwrite_show pos=%0d got=%h want=%h", pos, {dp, digit_en, segments}, want);
        end
      end
      load = (pos == 5) || (pos == 20);
      value_in = (pos == 5) ? 16'h00AB : 16'hCDEF;
      tick();
      load = 1'b0;
    end
    compared++;
  endtask

  task automatic test_bypass();
    logic [11:0] want;
    do_reset();
    while (pos < 32) tick();
    compared++;
    if (frame_tick !== 1'b1) begin
      mismatched++;
      $display("FAIL bypass_tick got=%b want=1", frame_tick);
    end
    value_in = 16'h4321;
    dp_in    = 4'b0001;
    load     = 1'b1;
    tick();
    load = 1'b0;
    while (pos < 64) begin
      want = expect_out(pos, 16'h4321, 4'b0001);
      compared++;
      if ({update_pending, dp, digit_en, segments} !== {1'b0, want}) begin
        mismatched++;
        $display("FAIL bypass_show pos=%0d got=%h want=%h", pos, {update_pending, dp, digit_en, segments}, {1'b0, want});
      end
      if (pos == 34) begin
        compared++;
        if ({dp, digit_en, segments} !== {1'b1, 4'b0001, 7'h06}) begin
          mismatched++;
          $display("FAIL bypass_digit0 got=%h want=%h", {dp, digit_en, segments}, {1'b1, 4'b0001, 7'h06});
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] want;
    do_reset();
    value_in = 16'h8888;
    dp_in    = 4'b0000;
    load     = 1'b1;
    tick();
    load = 1'b0;
    while (pos < 52) tick();
    compared++;
    if ({digit_en, segments} !== {4'b0100, 7'h7F}) begin
      mismatched++;
      $display("FAIL areset_before got=%h want=%h", {digit_en, segments}, {4'b0100, 7'h7F});
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({segments, dp, digit_en, frame_tick, update_pending} !== 14'h0) begin
      mismatched++;
      $display("FAIL areset_now got=%h want=0", {segments, dp, digit_en, frame_tick, update_pending});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pos   = 0;
    while (pos < 10) begin
      want = expect_out(pos, 16'h0, 4'h0);
      compared++;
      if ({dp, digit_en, segments} !== want) begin
        mismatched++;
        $display("FAIL areset_after pos=%0d got=%h want=%h", pos, {dp, digit_en, segments}, want);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    logic [11:0] want;
    do_reset();
    while (pos < 12) tick();
    ena = 1'b0;
    repeat (5) begin
      tick();
      compared++;
      if ({frame_tick, dp, digit_en, segments} !== 13'h0) begin
        mismatched++;
        $display("FAIL ena_off got=%h want=0", {frame_tick, dp, digit_en, segments});
      end
    end
    value_in = 16'h0005;
    dp_in    = 4'b0010;
    load     = 1'b1;
    tick();
    load = 1'b0;
    compared++;
    if ({update_pending, digit_en} !== {1'b1, 4'b0000}) begin
      mismatched++;
      $display("FAIL ena_off_load got=%h want=%h", {update_pending, digit_en}, {1'b1, 4'b0000});
    end
    ena = 1'b1;
    while (pos < 48) begin
      tick();
      want = (pos >= 33) ? expect_out(pos, 16'h0005, 4'b0010) : expect_out(pos, 16'h0, 4'h0);
      compared++;
      if ({frame_tick, dp, digit_en, segments} !== {pos == 32, want}) begin
        mismatched++;
        $display("FAIL ena_resume pos=%0d got=%h want=%h", pos, {frame_tick, dp, digit_en, segments}, {pos == 32, want});
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] tab [4] = '{7'h3F, 7'h6D, 7'h3F, 7'h3F};
`ifdef LZ_BLANK_EN
    logic [3:0] lit = 4'b0011;
`else
    logic [3:0] lit = 4'b1111;
`endif
    logic [11:0] want;
    int s;
    do_reset();
    value_in = 16'h0050;
    dp_in    = 4'b0000;
    load     = 1'b1;
    tick();
    load = 1'b0;
    while (pos < 33) tick();
    while (pos < 64) begin
      s = (pos / SD) % ND;
      want = (pos % SD < BC || !lit[s]) ? 12'h0 : {1'b0, 4'(1 << s), tab[s]};
      compared++;
      if ({dp, digit_en, segments} !== want) begin
        mismatched++;
        $display("FAIL lz pos=%0d got=%h want=%h", pos, {dp, digit_en, segments}, want);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_overwrite();
    test_bypass();
    test_async_reset();
    test_enable();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
